ac_motor_ramp_controller: RTL and testbench
===========================================

Name: ac_motor_ramp_controller

Overview:
Sequences the AC motor drive PWM path. It soft-starts and soft-stops the sine reference by slew-limiting two outputs toward their targets: the frequency step fed to the sine phase accumulator, and the amplitude level fed to the sine scaler. It gates the comparator ENABLE and latches external faults. It sits between the control interface (START/STOP/targets) and the sine generator and comparator.

Parameters:
FREQ_BITS, 16, width of frequency step (phase-accumulator increment)
LEVEL_BITS, 12, width of amplitude level (matches comparator level_bits)
RAMP_DIV, 1000, clock cycles per ramp tick (>=2)
FREQ_INC, 8, maximum frequency change per tick
LEVEL_INC, 4, maximum level change per tick

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
START  in  1  level; request run
STOP  in  1  level; request stop, overrides START
FAULT_IN  in  1  level; external fault (overcurrent/driver)
CLEAR  in  1  single-cycle pulse; acknowledge fault
TARGET_FREQ  in  FREQ_BITS  unsigned run frequency step
TARGET_LEVEL  in  LEVEL_BITS  unsigned run amplitude
FREQ_STEP  out  FREQ_BITS  slewed frequency step to sine generator
LEVEL  out  LEVEL_BITS  slewed amplitude to sine scaler
BRIDGE_EN  out  1  drives comparator ENABLE
STATE  out  3  current state encoding
FAULT  out  1  high while in S_FAULT

Behaviour:
- One clock, CLK. RST_N is asynchronous and active-low. Reset values: state=S_IDLE, FREQ_STEP=0, LEVEL=0, BRIDGE_EN=0, FAULT=0, prescaler=0. All outputs are registered.
- States: S_IDLE=0, S_RAMP_UP=1, S_RUN=2, S_RAMP_DOWN=3, S_FAULT=4.
- Event priority each cycle: FAULT_IN > STOP > START.
- Prescaler: counts 0..RAMP_DIV-1 while in RAMP_UP, RUN or RAMP_DOWN. tick=1 when count==RAMP_DIV-1, then wraps to 0. Cleared to 0 on every state change.
- Slew on tick: out += min(INC, target-out) if target>out; out -= min(INC, out-target) if target<out; unchanged if equal. Use unsigned arithmetic with no wrap. Outputs update in the same edge as the tick.
- S_IDLE: outputs 0, BRIDGE_EN=0. START&!STOP -> S_RAMP_UP, and BRIDGE_EN=1 from that edge.
- S_RAMP_UP: slew toward TARGET_*. When both outputs equal their targets after an update -> S_RUN on the next edge. STOP -> S_RAMP_DOWN.
- S_RUN: keeps tracking live TARGET_* changes with the same slew, staying in RUN. STOP -> S_RAMP_DOWN.
- S_RAMP_DOWN: slew both outputs toward 0. When both are 0 -> S_IDLE, with BRIDGE_EN=0 on that same edge. START&!STOP -> S_RAMP_UP from the current values, without a jump.
- FAULT_IN=1 in any state -> S_FAULT on the next edge. FREQ_STEP, LEVEL and BRIDGE_EN go to 0 on that edge (no ramp). FAULT=1.
- S_FAULT: exit to S_IDLE only on CLEAR=1 && FAULT_IN=0. CLEAR while FAULT_IN=1 is ignored. START is ignored in S_FAULT.
- Target of 0 in RAMP_UP: completes to RUN at 0/0. BRIDGE_EN stays 1.
- Reset mid-ramp: outputs drop to 0 immediately (asynchronous).

Decomposition:
- Package ac_motor_pkg holds the state encodings S_*, the STATE width (3), and the default INC/DIV constants shared with the sine generator.
- One sub-module, ac_motor_slew (parameter WIDTH, INC; ports CLK, RST_N, TICK, CLR, TARGET, OUT, AT_TARGET). It is instantiated twice, for frequency and level. CLR is the synchronous zero used for the fault path.

Test Plan:
- RAMP_DIV=4, FREQ_INC=10, LEVEL_INC=100, targets 25/250, START pulse held -> FREQ_STEP 10,20,25 and LEVEL 100,200,250 on ticks 1-3; STATE=RUN one edge after the third tick; BRIDGE_EN=1 from the first edge after START.
- In RUN, assert STOP -> outputs 15/150, 5/50, 0/0 on successive ticks; STATE=IDLE and BRIDGE_EN=0 on the edge where both reach 0.
- Mid RAMP_UP at 20/200, assert FAULT_IN -> next edge FREQ_STEP=0, LEVEL=0, BRIDGE_EN=0, FAULT=1, STATE=4. CLEAR with FAULT_IN=1 -> stays in S_FAULT. Drop FAULT_IN, then CLEAR -> S_IDLE.
- In RUN at 25/250, change TARGET_FREQ to 5 -> FREQ_STEP 15, then 5 on ticks; LEVEL stays 250; STATE stays RUN.
- During RAMP_DOWN at 15/150, reassert START -> S_RAMP_UP; next tick gives 25/250 with no discontinuity.
- Assert RST_N low mid-cycle in RUN -> all outputs 0 immediately, without waiting for CLK; STATE=IDLE after release.

Source files
------------

// File: rtl/ac_motor_pkg.sv
// Shared state encodings and default ramp constants for the AC motor drive path.
package ac_motor_pkg;

  localparam int STATE_W       = 3;
  localparam int DEF_RAMP_DIV  = 1000;
  localparam int DEF_FREQ_INC  = 8;
  localparam int DEF_LEVEL_INC = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_RUN       = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

endpackage

// File: rtl/ac_motor_ramp_controller_slew.sv
// Slew limiter: on TICK moves OUT at most INC toward TARGET without wrapping; CLR zeroes it.
module ac_motor_slew #(
  parameter int WIDTH = 16,
  parameter int INC   = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             TICK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] TARGET,
  output logic [WIDTH-1:0] OUT,
  output logic             AT_TARGET
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  logic [WIDTH-1:0] out_q, out_d, diff;

  always_comb begin
    out_d = out_q;
    diff  = '0;
    if (TARGET > out_q) begin
      diff  = TARGET - out_q;
      out_d = out_q + ((diff > INC_W) ? INC_W : diff);
    end else if (TARGET < out_q) begin
      diff  = out_q - TARGET;
      out_d = out_q - ((diff > INC_W) ? INC_W : diff);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    out_q <= '0;
    else if (CLR)  out_q <= '0;
    else if (TICK) out_q <= out_d;
  end

  assign OUT       = out_q;
  assign AT_TARGET = (out_q == TARGET);

endmodule

// File: rtl/ac_motor_ramp_controller.sv
// Run/stop/fault sequencer that soft-starts and soft-stops the sine reference and gates the bridge.
module ac_motor_ramp_controller
  import ac_motor_pkg::*;
#(
  parameter int FREQ_BITS  = 16,
  parameter int LEVEL_BITS = 12,
  parameter int RAMP_DIV   = DEF_RAMP_DIV,
  parameter int FREQ_INC   = DEF_FREQ_INC,
  parameter int LEVEL_INC  = DEF_LEVEL_INC
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  FAULT_IN,
  input  logic                  CLEAR,
  input  logic [FREQ_BITS-1:0]  TARGET_FREQ,
  input  logic [LEVEL_BITS-1:0] TARGET_LEVEL,
  output logic [FREQ_BITS-1:0]  FREQ_STEP,
  output logic [LEVEL_BITS-1:0] LEVEL,
  output logic                  BRIDGE_EN,
  output logic [STATE_W-1:0]    STATE,
  output logic                  FAULT
);

  localparam int CNT_W = $clog2(RAMP_DIV);
  localparam logic [FREQ_BITS-1:0]  FREQ_INC_W  = FREQ_BITS'(FREQ_INC);
  localparam logic [LEVEL_BITS-1:0] LEVEL_INC_W = LEVEL_BITS'(LEVEL_INC);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  bridge_q, bridge_d, fault_q, fault_d;
  logic                  active, tick, slew_clr, freq_at, level_at, down_done;
  logic [FREQ_BITS-1:0]  freq_q, freq_tgt;
  logic [LEVEL_BITS-1:0] level_q, level_tgt;

  assign active = (state_q == S_RAMP_UP) || (state_q == S_RUN) || (state_q == S_RAMP_DOWN);
  assign tick   = active && (cnt_q == CNT_W'(RAMP_DIV - 1));

  // Ramp-down finishes on the edge whose update lands both outputs on zero.
  assign down_done = ((freq_q == '0)  || (tick && freq_q  <= FREQ_INC_W)) &&
                     ((level_q == '0) || (tick && level_q <= LEVEL_INC_W));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (FAULT_IN) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE:      if (START && !STOP) state_d = S_RAMP_UP;
        S_RAMP_UP:   if (STOP) state_d = S_RAMP_DOWN;
                     else if (freq_at && level_at) state_d = S_RUN;
        S_RUN:       if (STOP) state_d = S_RAMP_DOWN;
        S_RAMP_DOWN: if (START && !STOP) state_d = S_RAMP_UP;
                     else if (down_done) state_d = S_IDLE;
        S_FAULT:     if (CLEAR) state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bridge_d  = (state_d == S_RAMP_UP) || (state_d == S_RUN) || (state_d == S_RAMP_DOWN);
    fault_d   = (state_d == S_FAULT);
    slew_clr  = (state_d == S_FAULT) || (state_d == S_IDLE);
    freq_tgt  = TARGET_FREQ;
    level_tgt = TARGET_LEVEL;
    if (state_q == S_RAMP_DOWN) begin
      freq_tgt  = '0;
      level_tgt = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!active || tick || (state_d != state_q)) cnt_d = '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q    <= '0;
      bridge_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bridge_q <= bridge_d;
      fault_q  <= fault_d;
    end
  end

  ac_motor_slew #(.WIDTH(FREQ_BITS), .INC(FREQ_INC)) u_freq (
    .CLK(CLK), .RST_N(RST_N), .TICK(tick), .CLR(slew_clr),
    .TARGET(freq_tgt), .OUT(freq_q), .AT_TARGET(freq_at)
  );

  ac_motor_slew #(.WIDTH(LEVEL_BITS), .INC(LEVEL_INC)) u_level (
    .CLK(CLK), .RST_N(RST_N), .TICK(tick), .CLR(slew_clr),
    .TARGET(level_tgt), .OUT(level_q), .AT_TARGET(level_at)
  );

  assign FREQ_STEP = freq_q;
  assign LEVEL     = level_q;
  assign BRIDGE_EN = bridge_q;
  assign STATE     = state_q;
  assign FAULT     = fault_q;

endmodule

// File: tb/tb_ac_motor_ramp_controller.sv
// Directed bench: ramp up/down, retarget, fault latch, restart from ramp-down, async reset.
module tb_ac_motor_ramp_controller;

  logic        CLK = 1'b0;
  logic        RST_N, START, STOP, FAULT_IN, CLEAR;
  logic [15:0] TARGET_FREQ, FREQ_STEP;
  logic [11:0] TARGET_LEVEL, LEVEL;
  logic        BRIDGE_EN, FAULT;
  logic [2:0]  STATE;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  ac_motor_ramp_controller #(
    .FREQ_BITS(16), .LEVEL_BITS(12), .RAMP_DIV(4), .FREQ_INC(10), .LEVEL_INC(100)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .FAULT_IN(FAULT_IN),
    .CLEAR(CLEAR), .TARGET_FREQ(TARGET_FREQ), .TARGET_LEVEL(TARGET_LEVEL),
    .FREQ_STEP(FREQ_STEP), .LEVEL(LEVEL), .BRIDGE_EN(BRIDGE_EN), .STATE(STATE),
    .FAULT(FAULT)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int f, input int l, input int br);
    chk({tag, ".state"}, int'(STATE), st);
    chk({tag, ".freq"},  int'(FREQ_STEP), f);
    chk({tag, ".level"}, int'(LEVEL), l);
    chk({tag, ".bridge"}, int'(BRIDGE_EN), br);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // START from IDLE with targets 25/250: ticks every 4 edges after entering RAMP_UP.
  task automatic ramp_up(input string tag);
    START = 1'b1;
    step(1); chk_all({tag, ".enter"}, 1, 0, 0, 1);
    step(4); chk_all({tag, ".t1"}, 1, 10, 100, 1);
    step(4); chk_all({tag, ".t2"}, 1, 20, 200, 1);
    step(4); chk_all({tag, ".t3"}, 1, 25, 250, 1);
    step(1); chk_all({tag, ".run"}, 2, 25, 250, 1);
    START = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; STOP = 1'b0; FAULT_IN = 1'b0; CLEAR = 1'b0;
    TARGET_FREQ = 16'd25; TARGET_LEVEL = 12'd250;
    #3;
    chk_all("rst", 0, 0, 0, 0);
    chk("rst.fault", int'(FAULT), 0);
    step(2);
    RST_N = 1'b1;
    step(1);
    chk_all("idle", 0, 0, 0, 0);

    ramp_up("up1");

    STOP = 1'b1;
    step(1); chk_all("dn.enter", 3, 25, 250, 1);
    step(4); chk_all("dn.t1", 3, 15, 150, 1);
    step(4); chk_all("dn.t2", 3, 5, 50, 1);
    step(3); chk_all("dn.pre", 3, 5, 50, 1);
    step(1); chk_all("dn.idle", 0, 0, 0, 0);
    STOP = 1'b0;

    ramp_up("up2");
    TARGET_FREQ = 16'd5;
    step(4); chk_all("retgt.t1", 2, 15, 250, 1);
    step(4); chk_all("retgt.t2", 2, 5, 250, 1);
    TARGET_FREQ = 16'd25;
    step(8); chk_all("retgt.back", 2, 25, 250, 1);

    STOP = 1'b1;
    step(1); chk_all("rd.enter", 3, 25, 250, 1);
    step(4); chk_all("rd.t1", 3, 15, 150, 1);
    STOP = 1'b0; START = 1'b1;
    step(1); chk_all("rd.reup", 1, 15, 150, 1);
    step(4); chk_all("rd.t2", 1, 25, 250, 1);
    step(1); chk_all("rd.run", 2, 25, 250, 1);
    START = 1'b0;

    #2 RST_N = 1'b0;
    #1 chk_all("arst", 0, 0, 0, 0);
    step(1);
    RST_N = 1'b1;
    step(1); chk_all("arst.rel", 0, 0, 0, 0);

    START = 1'b1;
    step(5); step(4); chk_all("flt.pre", 1, 20, 200, 1);
    FAULT_IN = 1'b1;
    step(1); chk_all("flt.enter", 4, 0, 0, 0);
    chk("flt.flag", int'(FAULT), 1);
    CLEAR = 1'b1; step(1); CLEAR = 1'b0;
    chk("flt.clr_ignored", int'(STATE), 4);
    FAULT_IN = 1'b0;
    step(2); chk("flt.hold", int'(STATE), 4);
    chk("flt.start_ignored", int'(BRIDGE_EN), 0);
    START = 1'b0;
    CLEAR = 1'b1; step(1); CLEAR = 1'b0;
    chk_all("flt.exit", 0, 0, 0, 0);
    chk("flt.flag_clr", int'(FAULT), 0);

    TARGET_FREQ = 16'd0; TARGET_LEVEL = 12'd0;
    START = 1'b1;
    step(1); chk_all("zero.up", 1, 0, 0, 1);
    step(1); chk_all("zero.run", 2, 0, 0, 1);
    START = 1'b0; STOP = 1'b1;
    step(1); chk("zero.dn", int'(STATE), 3);
    step(1); chk_all("zero.idle", 0, 0, 0, 0);
    STOP = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
